dff_bank_arbiter: RTL and testbench

//   Round-robin arbiter and write sequencer for one shared WIDTH-bit register

---
 rtl/dff_bank_arbiter_if.sv | 34 +++
 rtl/dff_bank_arbiter.sv | 128 ++++++++++++
 tb/tb_dff_bank_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dff_bank_arbiter_if.sv
// Purpose: bundles the requester-side bus of the shared register-bank arbiter.
// Latency: none (wiring only).
// Backpressure: none; requesters hold req until ack, the arbiter never stalls the bus itself.
interface dff_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       q;
    logic                   busy;

    // Requester side: drives requests and data, observes arbitration results.
    modport master (
        output req,
        output wdata,
        input  grant,
        input  ack,
        input  q,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  wdata,
        output grant,
        output ack,
        output q,
        output busy
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Purpose: round-robin arbiter that commits one requester's data per transaction into a shared register bank.
// Latency: req before edge k -> grant after edge k -> q and ack after edge k+1; one write per 2 cycles sustained.
// Backpressure: losers simply keep req asserted; a winner dropping req while granted aborts without a write.
module dff_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_async_n,
    input  logic               clr_sync,
    dff_bank_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW    = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] win, win_nxt;
    logic [IDX_W-1:0] pick;
    logic             pick_vld;
    logic [CW-1:0]    cand;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant_r, grant_nxt;
    logic [N_REQ-1:0] ack_r, ack_nxt;
    logic [WIDTH-1:0] q_r;
    logic             wr_en;

    // The requester just acked is not eligible again in its DONE cycle.
    always_comb begin
        elig = bus.req;
        if (state == DONE) begin
            elig[win] = 1'b0;
        end
    end

    // Wrap-around priority search starting at ptr; first eligible requester wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!pick_vld && elig[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        grant_nxt = '0;
        ack_nxt   = '0;
        wr_en     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (pick_vld) begin
                    win_nxt         = pick;
                    grant_nxt[pick] = 1'b1;
                    state_nxt       = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (bus.req[win]) begin
                    wr_en        = 1'b1;
                    ack_nxt[win] = 1'b1;
                    ptr_nxt      = (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
                    state_nxt    = DONE;
                end else begin
                    // Winner withdrew: no write, priority stays where it was.
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM, priority pointer, winner index and grant/ack registers.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            grant_r <= '0;
            ack_r   <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            win     <= win_nxt;
            grant_r <= grant_nxt;
            ack_r   <= ack_nxt;
        end
    end

    // Register bank: synchronous clear beats a coincident write, whose data is dropped.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            q_r <= '0;
        end else if (clr_sync) begin
            q_r <= '0;
        end else if (wr_en) begin
            q_r <= bus.wdata[int'(win)*WIDTH +: WIDTH];
        end
    end

    assign bus.grant = grant_r;
    assign bus.ack   = ack_r;
    assign bus.q     = q_r;
    assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Purpose: self-checking bench for dff_bank_arbiter (vector table, corner sequences, randomized model compare).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: bench-driven requesters follow the drop-on-ack rule except in the random phase.
module tb_dff_bank_arbiter;

    localparam logic [31:0] WD = 32'h773C11A5; // lanes 3..0 = 77, 3C, 11, A5

    logic clk;
    logic rst_n;
    logic clr;

    int n_cmp;
    int n_bad;

    dff_bank_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    dff_bank_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk         (clk),
        .rst_async_n (rst_n),
        .clr_sync    (clr),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic        clr;
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic [7:0]  q;
        logic        busy;
    } vec_t;

    vec_t vt [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] a,
                             input logic [7:0] qv, input logic b);
        check({tag, ".grant"}, 32'(bus.grant), 32'(g));
        check({tag, ".ack"},   32'(bus.ack),   32'(a));
        check({tag, ".q"},     32'(bus.q),     32'(qv));
        check({tag, ".busy"},  32'(bus.busy),  32'(b));
    endtask

    task automatic step(input logic [3:0] r, input logic [31:0] d, input logic c);
        @(negedge clk);
        bus.req   = r;
        bus.wdata = d;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model: transaction-level view with plain integers.
    int          m_w;    // requester holding grant, -1 if none
    int          m_a;    // requester being acked, -1 if none
    int          m_ptr;
    logic [7:0]  m_q;

    task automatic model_step(input logic [3:0] r, input logic [31:0] d, input logic c);
        int nw;
        int na;
        int k;
        logic [3:0] el;
        nw = -1;
        na = -1;
        if (m_w >= 0) begin
            if (r[m_w]) begin
                m_q   = d[m_w*8 +: 8];
                na    = m_w;
                m_ptr = (m_w + 1) % 4;
            end
        end else begin
            el = r;
            if (m_a >= 0) el[m_a] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (nw < 0 && el[k]) nw = k;
            end
        end
        if (c) m_q = 8'h00;
        m_w = nw;
        m_a = na;
    endtask

    initial begin
        logic [3:0]  r;
        logic [31:0] d;
        logic        c;
        logic [3:0]  eg;
        logic [3:0]  ea;
        int          k;

        n_cmp = 0;
        n_bad = 0;

        //               req      wdata clr grant    ack      q      busy
        vt[0]  = '{4'b0001, WD, 1'b0, 4'b0001, 4'b0000, 8'h00, 1'b1};
        vt[1]  = '{4'b0001, WD, 1'b0, 4'b0000, 4'b0001, 8'hA5, 1'b1};
        vt[2]  = '{4'b0000, WD, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0};
        vt[3]  = '{4'b0100, WD, 1'b0, 4'b0100, 4'b0000, 8'hA5, 1'b1};
        vt[4]  = '{4'b0100, WD, 1'b0, 4'b0000, 4'b0100, 8'h3C, 1'b1};
        vt[5]  = '{4'b1001, WD, 1'b0, 4'b1000, 4'b0000, 8'h3C, 1'b1};
        vt[6]  = '{4'b1001, WD, 1'b0, 4'b0000, 4'b1000, 8'h77, 1'b1};
        vt[7]  = '{4'b0001, WD, 1'b0, 4'b0001, 4'b0000, 8'h77, 1'b1};
        vt[8]  = '{4'b0001, WD, 1'b0, 4'b0000, 4'b0001, 8'hA5, 1'b1};
        vt[9]  = '{4'b0000, WD, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0};
        vt[10] = '{4'b0010, WD, 1'b0, 4'b0010, 4'b0000, 8'hA5, 1'b1};
        vt[11] = '{4'b0000, WD, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0};
        vt[12] = '{4'b0011, WD, 1'b0, 4'b0010, 4'b0000, 8'hA5, 1'b1};
        vt[13] = '{4'b0010, WD, 1'b0, 4'b0000, 4'b0010, 8'h11, 1'b1};
        vt[14] = '{4'b0000, WD, 1'b0, 4'b0000, 4'b0000, 8'h11, 1'b0};
        vt[15] = '{4'b0100, WD, 1'b0, 4'b0100, 4'b0000, 8'h11, 1'b1};
        vt[16] = '{4'b0100, WD, 1'b1, 4'b0000, 4'b0100, 8'h00, 1'b1};
        vt[17] = '{4'b0000, WD, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0};
        vt[18] = '{4'b0001, WD, 1'b0, 4'b0001, 4'b0000, 8'h00, 1'b1};
        vt[19] = '{4'b0001, WD, 1'b0, 4'b0000, 4'b0001, 8'hA5, 1'b1};
        vt[20] = '{4'b0000, WD, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0};

        // Reset state, before any clock edge.
        rst_n     = 1'b0;
        clr       = 1'b0;
        bus.req   = 4'b0000;
        bus.wdata = 32'h0;
        #1;
        check_all("reset", 4'b0000, 4'b0000, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, wrap-around, abort, clr_sync collision.
        for (int i = 0; i < 21; i++) begin
            step(vt[i].req, vt[i].wdata, vt[i].clr);
            check_all($sformatf("vec%0d", i), vt[i].grant, vt[i].ack, vt[i].q, vt[i].busy);
        end

        // Async reset in the middle of a grant (ptr is 1 at this point).
        step(4'b0100, WD, 1'b0);
        check_all("arst.pre", 4'b0100, 4'b0000, 8'h00, 1'b1);
        step(4'b0001, WD, 1'b0);
        check_all("arst.wr", 4'b0000, 4'b0000, 8'h00, 1'b0);
        step(4'b0100, WD, 1'b0);
        check_all("arst.grant", 4'b0100, 4'b0000, 8'h00, 1'b1);
        step(4'b0100, WD, 1'b0);
        check_all("arst.q", 4'b0000, 4'b0100, 8'h3C, 1'b1);
        step(4'b0010, WD, 1'b0);
        check_all("arst.g2", 4'b0010, 4'b0000, 8'h3C, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("arst.now", 4'b0000, 4'b0000, 8'h00, 1'b0);
        #1;
        bus.req = 4'b0000;
        rst_n   = 1'b1;
        step(4'b0000, WD, 1'b0);
        check_all("arst.noack", 4'b0000, 4'b0000, 8'h00, 1'b0);
        step(4'b1111, WD, 1'b0);
        check_all("arst.first", 4'b0001, 4'b0000, 8'h00, 1'b1);

        // Fairness: all requesters busy, each drops req during its ack cycle.
        k = 0;
        for (int n = 0; n < 8; n++) begin
            ea = 4'b0001 << k;
            step(4'b1111, WD, 1'b0);
            check_all($sformatf("fair%0d.ack", n), 4'b0000, ea, WD[k*8 +: 8], 1'b1);
            k  = (k + 1) % 4;
            eg = 4'b0001 << k;
            step(4'b1111 & ~ea, WD, 1'b0);
            check_all($sformatf("fair%0d.grant", n), eg, 4'b0000, WD[((k+3)%4)*8 +: 8], 1'b1);
        end

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = 4'b0000;
        clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_w   = -1;
        m_a   = -1;
        m_ptr = 0;
        m_q   = 8'h00;
        for (int n = 0; n < 400; n++) begin
            r = 4'($urandom_range(0, 15));
            d = $urandom;
            c = ($urandom_range(0, 9) == 0);
            model_step(r, d, c);
            step(r, d, c);
            eg = (m_w >= 0) ? (4'b0001 << m_w) : 4'b0000;
            ea = (m_a >= 0) ? (4'b0001 << m_a) : 4'b0000;
            check_all($sformatf("rand%0d", n), eg, ea, m_q, (m_w >= 0) || (m_a >= 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
